regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the single register-file write port (WE3/A3/WD3) between the in-order pipeline writeback stage
//   and a multi-cycle execution unit (mul/div, valid/ready). Keeps a destination scoreboard so decode can
//   stall on operands still owned by the multi-cycle unit. Sits between WB/MDU and Register_File.
// PARAMETERS
//   XLEN          64   data width of write data
//   STARVE_LIMIT  4    consecutive blocked cycles of m_valid before the pipeline is stalled (>=1)
// PORTS
//   clk        in   1     clock, rising edge
//   rst        in   1     reset, asynchronous, active-low
//   p_we       in   1     pipeline WB write enable
//   p_rd       in   5     pipeline WB destination
//   p_wd       in   XLEN  pipeline WB data
//   m_valid    in   1     multi-cycle result valid
//   m_ready    out  1     multi-cycle result accepted this cycle (combinational)
//   m_rd       in   5     multi-cycle destination
//   m_wd       in   XLEN  multi-cycle data
//   iss_valid  in   1     long-latency op issued to multi-cycle unit this cycle
//   iss_rd     in   5     its destination
//   chk_rs1    in   5     decode source 1
//   chk_rs2    in   5     decode source 2
//   hazard     out  1     chk_rs1 or chk_rs2 busy in scoreboard (combinational)
//   stall_pipe out  1     registered; pipeline must freeze WB and re-present same write
//   rf_we      out  1     registered write enable to register file
//   rf_a3      out  5     registered write address
//   rf_wd      out  XLEN  registered write data
// BEHAVIOUR
//   Reset (rst=0, async): rf_we=0, rf_a3=0, rf_wd=0, stall_pipe=0, scoreboard all clear,
//     starve_cnt=0, state=NORMAL. Reset mid-operation discards any pending grant/stall.
//   Latency: granted write appears on rf_* exactly 1 cycle after grant; rf_we high for 1 cycle per grant.
//   States:
//     NORMAL: pipeline priority. m_ready = m_valid & ~p_we. Grant P if p_we, else M if m_valid.
//       starve_cnt +1 each cycle m_valid & ~m_ready (saturating); cleared on M grant or ~m_valid.
//       If blocked this cycle and starve_cnt == STARVE_LIMIT-1 -> DRAIN, stall_pipe=1 next cycle.
//     DRAIN: stall_pipe=1; p_we ignored (pipeline holds it); m_ready = m_valid.
//       M handshake -> NORMAL, stall_pipe=0 next cycle, starve_cnt=0.
//       m_valid low -> NORMAL, stall_pipe=0 next cycle, no write.
//   Handshake: M transfer occurs when m_valid & m_ready; m_rd/m_wd must hold while m_valid & ~m_ready.
//   x0: a granted write with rd=0 consumes the grant but drives rf_we=0. x0 never marked busy.
//   Scoreboard (32 bits): set bit iss_rd on iss_valid (iss_rd!=0); clear bit m_rd on M handshake.
//     Same register set and cleared same cycle -> set wins. Update visible to hazard next cycle.
//   hazard = busy[chk_rs1] | busy[chk_rs2]; index 0 always reads 0.
//   No idle write: neither granted -> rf_we=0, rf_a3/rf_wd hold previous values.
// TESTING
//   p_we=1 rd=5 wd=0xA, m_valid=0 -> next cycle rf_we=1 rf_a3=5 rf_wd=0xA; m_ready stays 0.
//   p_we=0, m_valid=1 rd=7 wd=0x77 -> m_ready=1 same cycle; next cycle rf_a3=7 rf_wd=0x77.
//   p_we=1 every cycle, m_valid=1 -> m_ready=0 cycles 0..3, stall_pipe=1 from cycle 4, M granted there,
//     stall_pipe=0 the following cycle.
//   iss_valid rd=9; chk_rs1=9 -> hazard=1 next cycle; after M handshake rd=9 -> hazard=0 next cycle.
//   iss_valid rd=0 or M write rd=0 -> scoreboard unchanged, rf_we=0; hazard for chk_rs1=0 is 0.
//   rst pulled low during DRAIN with busy bits set -> stall_pipe=0, rf_we=0, hazard=0 immediately.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback stage and a
// multi-cycle unit. It also tracks destinations still owned by the multi-cycle unit so decode can stall on them.
module regfile_write_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_we,
  input  logic [4:0]      p_rd,
  input  logic [XLEN-1:0] p_wd,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hazard,
  output logic            stall_pipe,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic            fsm_state
);

  // Multi-cycle handshake: a result transfers in the cycle where m_valid & m_ready are both high;
  // while m_valid is high and m_ready low, the unit must hold m_rd/m_wd stable.

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   starve_cnt, starve_cnt_next;
  logic [31:0]     busy, busy_next;
  logic            grant_p, grant_m, blocked;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_wd;
  logic            wr_en;

  assign fsm_state = state;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NORMAL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      NORMAL: begin
        if (blocked && (starve_cnt == CW'(STARVE_LIMIT - 1))) next_state = DRAIN;
      end
      DRAIN: begin
        if (grant_m || !m_valid) next_state = NORMAL;
      end
      default: next_state = NORMAL;
    endcase
  end

  // Output logic: pipeline has priority except while draining a starved result
  always_comb begin
    m_ready = 1'b0;
    grant_p = 1'b0;
    grant_m = 1'b0;
    blocked = 1'b0;
    case (state)
      NORMAL: begin
        grant_p = p_we;
        grant_m = m_valid & ~p_we;
        m_ready = m_valid & ~p_we;
        blocked = m_valid & p_we;
      end
      DRAIN: begin
        grant_m = m_valid;
        m_ready = m_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_next = '0;
    if (state == NORMAL && blocked) begin
      if (starve_cnt != CW'(STARVE_LIMIT)) starve_cnt_next = starve_cnt + 1'b1;
      else                                 starve_cnt_next = starve_cnt;
    end
  end

  // A grant to x0 is consumed but never reaches the register file
  assign wr_rd = grant_p ? p_rd : m_rd;
  assign wr_wd = grant_p ? p_wd : m_wd;
  assign wr_en = (grant_p | grant_m) && (wr_rd != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_pipe <= 1'b0;
      rf_we      <= 1'b0;
      rf_a3      <= 5'd0;
      rf_wd      <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
      stall_pipe <= (next_state == DRAIN);
      rf_we      <= wr_en;
      if (wr_en) begin
        rf_a3 <= wr_rd;
        rf_wd <= wr_wd;
      end
    end
  end

  // Scoreboard: a new issue to a register wins over a retirement of the same register
  always_comb begin
    busy_next = busy;
    if (grant_m) busy_next[m_rd] = 1'b0;
    if (iss_valid && iss_rd != 5'd0) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign hazard = busy[chk_rs1] | busy[chk_rs2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, starvation and reset corner sequences,
// then randomized traffic compared against a reference model.
module tb_regfile_write_arbiter;

  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            p_we;
  logic [4:0]      p_rd;
  logic [XLEN-1:0] p_wd;
  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wd;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            hazard;
  logic            stall_pipe;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd;
  logic            fsm_state;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_wd(m_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .hazard(hazard), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .fsm_state(fsm_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic            p_we;
    logic [4:0]      p_rd;
    logic [XLEN-1:0] p_wd;
    logic            m_valid;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_wd;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            e_ready;
    logic            e_haz;
    logic            e_we;
    logic [4:0]      e_a3;
    logic [XLEN-1:0] e_wd;
    logic            e_stall;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic pwe, logic [4:0] prd, logic [XLEN-1:0] pwd,
                              logic mv, logic [4:0] mrd, logic [XLEN-1:0] mwd,
                              logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                              logic erdy, logic ehaz, logic ewe, logic [4:0] ea3,
                              logic [XLEN-1:0] ewd, logic estall);
    vec_t v;
    v.p_we = pwe; v.p_rd = prd; v.p_wd = pwd;
    v.m_valid = mv; v.m_rd = mrd; v.m_wd = mwd;
    v.iss_valid = iv; v.iss_rd = ird; v.rs1 = r1; v.rs2 = r2;
    v.e_ready = erdy; v.e_haz = ehaz; v.e_we = ewe; v.e_a3 = ea3; v.e_wd = ewd; v.e_stall = estall;
    return v;
  endfunction

  // Scoreboard compare
  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(logic pwe, logic [4:0] prd, logic [XLEN-1:0] pwd,
                       logic mv, logic [4:0] mrd, logic [XLEN-1:0] mwd,
                       logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2);
    p_we = pwe; p_rd = prd; p_wd = pwd;
    m_valid = mv; m_rd = mrd; m_wd = mwd;
    iss_valid = iv; iss_rd = ird; chk_rs1 = r1; chk_rs2 = r2;
  endtask

  task automatic idle(logic [4:0] r1);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, r1, 5'd0);
  endtask

  // Called at a negedge with inputs already driven: checks comb outputs, crosses one posedge,
  // checks registered outputs, and returns at the next negedge.
  task automatic cycle_check(string tag, logic erdy, logic ehaz, logic ewe,
                             logic [4:0] ea3, logic [XLEN-1:0] ewd, logic estall, logic chk_addr);
    #1;
    check({tag, ".m_ready"}, XLEN'(m_ready), XLEN'(erdy));
    check({tag, ".hazard"}, XLEN'(hazard), XLEN'(ehaz));
    @(posedge clk); #1;
    check({tag, ".rf_we"}, XLEN'(rf_we), XLEN'(ewe));
    check({tag, ".stall_pipe"}, XLEN'(stall_pipe), XLEN'(estall));
    if (chk_addr) begin
      check({tag, ".rf_a3"}, XLEN'(rf_a3), XLEN'(ea3));
      check({tag, ".rf_wd"}, rf_wd, ewd);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(5'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model state
  bit              mdl_busy[32];
  int              mdl_starve;
  bit              mdl_drain;
  logic            mdl_we;
  logic [4:0]      mdl_a3;
  logic [XLEN-1:0] mdl_wd;

  task automatic model_reset();
    foreach (mdl_busy[i]) mdl_busy[i] = 1'b0;
    mdl_starve = 0; mdl_drain = 1'b0;
    mdl_we = 1'b0; mdl_a3 = 5'd0; mdl_wd = '0;
  endtask

  initial begin
    // Directed table, starting from reset
    tbl[0]  = mk(1, 5'd5,  64'hA,  0, 5'd0,  64'h0,  0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 5'd5,  64'hA,  0);
    tbl[1]  = mk(0, 5'd0,  64'h0,  1, 5'd7,  64'h77, 0, 5'd0,  5'd0,  5'd0,  1, 0, 1, 5'd7,  64'h77, 0);
    tbl[2]  = mk(0, 5'd0,  64'h0,  0, 5'd0,  64'h0,  1, 5'd9,  5'd9,  5'd0,  0, 0, 0, 5'd7,  64'h77, 0);
    tbl[3]  = mk(0, 5'd0,  64'h0,  0, 5'd0,  64'h0,  0, 5'd0,  5'd9,  5'd0,  0, 1, 0, 5'd7,  64'h77, 0);
    tbl[4]  = mk(0, 5'd0,  64'h0,  1, 5'd9,  64'h99, 0, 5'd0,  5'd0,  5'd9,  1, 1, 1, 5'd9,  64'h99, 0);
    tbl[5]  = mk(0, 5'd0,  64'h0,  0, 5'd0,  64'h0,  0, 5'd0,  5'd9,  5'd9,  0, 0, 0, 5'd9,  64'h99, 0);
    tbl[6]  = mk(1, 5'd0,  64'h55, 0, 5'd0,  64'h0,  1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 5'd9,  64'h99, 0);
    tbl[7]  = mk(0, 5'd0,  64'h0,  1, 5'd0,  64'h11, 1, 5'd12, 5'd12, 5'd0,  1, 0, 0, 5'd9,  64'h99, 0);
    tbl[8]  = mk(0, 5'd0,  64'h0,  1, 5'd12, 64'hC,  1, 5'd12, 5'd12, 5'd0,  1, 1, 1, 5'd12, 64'hC,  0);
    tbl[9]  = mk(0, 5'd0,  64'h0,  0, 5'd0,  64'h0,  0, 5'd0,  5'd0,  5'd12, 0, 1, 0, 5'd12, 64'hC,  0);
    tbl[10] = mk(0, 5'd0,  64'h0,  1, 5'd12, 64'hD,  0, 5'd0,  5'd12, 5'd0,  1, 1, 1, 5'd12, 64'hD,  0);
    tbl[11] = mk(0, 5'd0,  64'h0,  0, 5'd0,  64'h0,  0, 5'd0,  5'd12, 5'd0,  0, 0, 0, 5'd12, 64'hD,  0);

    rst = 1'b0;
    idle(5'd0);
    @(negedge clk); #1;
    check("reset.rf_we", XLEN'(rf_we), '0);
    check("reset.rf_a3", XLEN'(rf_a3), '0);
    check("reset.rf_wd", rf_wd, '0);
    check("reset.stall_pipe", XLEN'(stall_pipe), '0);
    check("reset.m_ready", XLEN'(m_ready), '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].p_we, tbl[i].p_rd, tbl[i].p_wd, tbl[i].m_valid, tbl[i].m_rd, tbl[i].m_wd,
            tbl[i].iss_valid, tbl[i].iss_rd, tbl[i].rs1, tbl[i].rs2);
      cycle_check($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_haz, tbl[i].e_we,
                  tbl[i].e_a3, tbl[i].e_wd, tbl[i].e_stall, 1'b1);
    end

    // Starvation: pipeline writes every cycle while a multi-cycle result waits
    drive(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd3, 5'd0, 5'd0);
    cycle_check("starve.iss", 0, 0, 0, 5'd12, 64'hD, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(1, 5'(c + 1), 64'h100 + 64'(c), 1, 5'd3, 64'h33, 0, 5'd0, 5'd3, 5'd0);
      if (c < 4)
        cycle_check($sformatf("starve%0d", c), 0, 1, 1, 5'(c + 1), 64'h100 + 64'(c), c == 3, 1'b1);
      else
        cycle_check("starve.drain", 1, 1, 1, 5'd3, 64'h33, 0, 1'b1);
    end
    idle(5'd3);
    cycle_check("starve.clear", 0, 0, 0, 5'd3, 64'h33, 0, 1'b1);

    // Reset asserted while draining with a busy register
    drive(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd4, 5'd4, 5'd0);
    cycle_check("rstdrain.iss", 0, 0, 0, 5'd3, 64'h33, 0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(1, 5'd8, 64'h80, 1, 5'd4, 64'h44, 0, 5'd0, 5'd4, 5'd0);
      cycle_check($sformatf("rstdrain%0d", c), 0, 1, 1, 5'd8, 64'h80, c == 3, 1'b1);
    end
    #1;
    rst = 1'b0;
    #1;
    check("rstdrain.stall_pipe", XLEN'(stall_pipe), '0);
    check("rstdrain.rf_we", XLEN'(rf_we), '0);
    check("rstdrain.hazard", XLEN'(hazard), '0);
    @(negedge clk);
    idle(5'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the reference model
    model_reset();
    begin
      bit              pending;
      logic            e_ready, e_haz, grant_m, blocked;
      logic [4:0]      g_rd;
      logic [XLEN-1:0] g_wd;
      bit              granted;
      pending = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if (!pending) begin
          m_valid = ($urandom_range(0, 2) != 0);
          m_rd    = 5'($urandom_range(0, 31));
          m_wd    = {32'($urandom), 32'($urandom)};
        end else if ($urandom_range(0, 15) == 0) begin
          m_valid = 1'b0;
        end
        p_we      = ($urandom_range(0, 3) != 0);
        p_rd      = 5'($urandom_range(0, 31));
        p_wd      = {32'($urandom), 32'($urandom)};
        iss_valid = ($urandom_range(0, 2) == 0);
        iss_rd    = 5'($urandom_range(0, 31));
        chk_rs1   = 5'($urandom_range(0, 31));
        chk_rs2   = 5'($urandom_range(0, 31));

        // Pipeline wins unless a starved result is being drained
        e_ready = m_valid && (mdl_drain || !p_we);
        e_haz   = (chk_rs1 != 0 && mdl_busy[chk_rs1]) || (chk_rs2 != 0 && mdl_busy[chk_rs2]);
        grant_m = e_ready;
        granted = 1'b0; g_rd = 5'd0; g_wd = '0;
        if (!mdl_drain && p_we) begin granted = 1'b1; g_rd = p_rd; g_wd = p_wd; end
        else if (m_valid)       begin granted = 1'b1; g_rd = m_rd; g_wd = m_wd; end

        #1;
        check("rnd.m_ready", XLEN'(m_ready), XLEN'(e_ready));
        check("rnd.hazard", XLEN'(hazard), XLEN'(e_haz));

        mdl_we = granted && g_rd != 0;
        if (mdl_we) begin mdl_a3 = g_rd; mdl_wd = g_wd; end
        if (grant_m) mdl_busy[m_rd] = 1'b0;
        if (iss_valid && iss_rd != 0) mdl_busy[iss_rd] = 1'b1;
        blocked = !mdl_drain && m_valid && p_we;
        if (mdl_drain) begin
          mdl_drain  = 1'b0;
          mdl_starve = 0;
        end else if (blocked) begin
          mdl_drain  = (mdl_starve + 1 >= LIMIT);
          mdl_starve = mdl_starve + 1;
        end else begin
          mdl_starve = 0;
        end
        pending = m_valid && !e_ready;

        @(posedge clk); #1;
        check("rnd.rf_we", XLEN'(rf_we), XLEN'(mdl_we));
        check("rnd.rf_a3", XLEN'(rf_a3), XLEN'(mdl_a3));
        check("rnd.rf_wd", rf_wd, mdl_wd);
        check("rnd.stall_pipe", XLEN'(stall_pipe), XLEN'(mdl_drain));
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
